// File: rtl/sva_mon_pkg.sv
// Shared types for the deferred-evaluation check monitor.
// Channel modes and event kinds use the same 2-bit encoding.
package sva_mon_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_ASSERT = 2'b01,
        MODE_ASSUME = 2'b10,
        MODE_COVER  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        KIND_NONE        = 2'b00,
        KIND_ASSERT_FAIL = 2'b01,
        KIND_ASSUME_FAIL = 2'b10,
        KIND_COVER_HIT   = 2'b11
    } kind_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sva_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is taken when
// a pop happens in the same cycle.
module sva_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sva_check_monitor.sv
// Multi-channel deferred checker: registers check inputs, judges them a
// cycle later, keeps counters/sticky status and streams timestamped events.
module sva_check_monitor
    import sva_mon_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       chk_en,
    input  logic [NUM_CH-1:0]       chk_cond,
    input  logic [2*NUM_CH-1:0]     chk_mode,
    input  logic                    clr,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [idx_w(NUM_CH)-1:0] evt_chan,
    output logic [1:0]              evt_kind,
    output logic [TS_W-1:0]         evt_ts,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt,
    output logic [NUM_CH*CNT_W-1:0] hit_cnt,
    output logic                    any_fail,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int CH_W = idx_w(NUM_CH);

    typedef struct packed {
        logic [CH_W-1:0] chan;
        kind_e           kind;
        logic [TS_W-1:0] ts;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [NUM_CH-1:0]   en_q, cond_q;
    logic [2*NUM_CH-1:0] mode_q;
    logic                clr_q;
    logic [TS_W-1:0]     ts_q, s0_ts_q;

    logic [NUM_CH-1:0][CNT_W-1:0] fail_q, fail_d, hit_q, hit_d;
    logic [NUM_CH-1:0]            armed_q, armed_d;
    logic                         any_q, any_d;
    logic [CNT_W-1:0]             drop_q, drop_d;

    logic [NUM_CH-1:0]            sfull_q, sfull_d;
    logic [NUM_CH-1:0][1:0]       skind_q, skind_d;
    logic [NUM_CH-1:0][TS_W-1:0]  sts_q, sts_d;

    logic            grant_found;
    logic [CH_W-1:0] grant_idx;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    evt_t            push_evt, head_evt;
    logic [EVT_W-1:0] fifo_rdata;
    mode_e           m;
    logic            is_fail, is_hit, raise;

    // Stage S0: capture everything judged in the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            cond_q  <= '0;
            mode_q  <= '0;
            clr_q   <= 1'b0;
            ts_q    <= '0;
            s0_ts_q <= '0;
        end else begin
            en_q    <= chk_en;
            cond_q  <= chk_cond;
            mode_q  <= chk_mode;
            clr_q   <= clr;
            ts_q    <= ts_q + 1'b1;
            s0_ts_q <= ts_q;
        end
    end

    always_comb begin
        fail_d      = fail_q;
        hit_d       = hit_q;
        armed_d     = armed_q;
        any_d       = any_q;
        drop_d      = drop_q;
        sfull_d     = sfull_q;
        skind_d     = skind_q;
        sts_d       = sts_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        m           = MODE_OFF;
        is_fail     = 1'b0;
        is_hit      = 1'b0;
        raise       = 1'b0;

        for (int i = 0; i < NUM_CH; i++) begin
            if (sfull_q[i] && !grant_found) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(i);
            end
        end
        push = grant_found && (!fifo_full || pop);
        if (push) sfull_d[grant_idx] = 1'b0;

        if (clr_q) begin
            fail_d  = '0;
            hit_d   = '0;
            armed_d = '1;
            any_d   = 1'b0;
            drop_d  = '0;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            m       = mode_e'(mode_q[2*i +: 2]);
            is_fail = en_q[i] && !cond_q[i] &&
                      (m == MODE_ASSERT || m == MODE_ASSUME);
            is_hit  = en_q[i] && cond_q[i] && (m == MODE_COVER);
            raise   = 1'b0;
            if (is_fail) begin
                fail_d[i] = sat_inc(fail_d[i]);
                any_d     = 1'b1;
                raise     = 1'b1;
            end
            if (is_hit) begin
                hit_d[i]   = sat_inc(hit_d[i]);
                raise      = armed_d[i];
                armed_d[i] = 1'b0;
            end
            // A slot freed by the arbiter this cycle can take a new event
            if (raise) begin
                if (sfull_d[i]) begin
                    drop_d = sat_inc(drop_d);
                end else begin
                    sfull_d[i] = 1'b1;
                    skind_d[i] = m;
                    sts_d[i]   = s0_ts_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_q  <= '0;
            hit_q   <= '0;
            armed_q <= '1;
            any_q   <= 1'b0;
            drop_q  <= '0;
            sfull_q <= '0;
            skind_q <= '0;
            sts_q   <= '0;
        end else begin
            fail_q  <= fail_d;
            hit_q   <= hit_d;
            armed_q <= armed_d;
            any_q   <= any_d;
            drop_q  <= drop_d;
            sfull_q <= sfull_d;
            skind_q <= skind_d;
            sts_q   <= sts_d;
        end
    end

    assign push_evt.chan = grant_idx;
    assign push_evt.kind = kind_e'(skind_q[grant_idx]);
    assign push_evt.ts   = sts_q[grant_idx];

    sva_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_evt),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_evt  = evt_t'(fifo_rdata);
    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign evt_chan  = evt_valid ? head_evt.chan : '0;
    assign evt_kind  = evt_valid ? head_evt.kind : 2'b00;
    assign evt_ts    = evt_valid ? head_evt.ts : '0;
    assign fail_cnt  = fail_q;
    assign hit_cnt   = hit_q;
    assign any_fail  = any_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sva_check_monitor.sv
// Directed-vector bench for the deferred check monitor.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sva_check_monitor;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 5;
    localparam int TS_W       = 8;
    localparam int FIFO_DEPTH = 8;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH-1:0]       chk_en;
    logic [NUM_CH-1:0]       chk_cond;
    logic [2*NUM_CH-1:0]     chk_mode;
    logic                    clr;
    logic                    evt_valid;
    logic                    evt_ready;
    logic [1:0]              evt_chan;
    logic [1:0]              evt_kind;
    logic [TS_W-1:0]         evt_ts;
    logic [NUM_CH*CNT_W-1:0] fail_cnt;
    logic [NUM_CH*CNT_W-1:0] hit_cnt;
    logic                    any_fail;
    logic [CNT_W-1:0]        drop_cnt;

    sva_check_monitor #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .TS_W       (TS_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .chk_en    (chk_en),
        .chk_cond  (chk_cond),
        .chk_mode  (chk_mode),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_chan  (evt_chan),
        .evt_kind  (evt_kind),
        .evt_ts    (evt_ts),
        .fail_cnt  (fail_cnt),
        .hit_cnt   (hit_cnt),
        .any_fail  (any_fail),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running timestamp as the bench expects it
    logic [TS_W-1:0] tb_ts;
    always @(posedge clk) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    int             n_evt;
    logic [1:0]     ev_chan [32];
    logic [1:0]     ev_kind [32];
    logic [TS_W-1:0] ev_ts  [32];
    int             ev_cyc  [32];

    task automatic collect(input int cycles);
        n_evt = 0;
        for (int k = 0; k < 32; k++) begin
            ev_chan[k] = 2'bxx;
            ev_kind[k] = 2'bxx;
            ev_ts[k]   = 'x;
            ev_cyc[k]  = -1;
        end
        evt_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (evt_valid === 1'b1 && n_evt < 32) begin
                ev_chan[n_evt] = evt_chan;
                ev_kind[n_evt] = evt_kind;
                ev_ts[n_evt]   = evt_ts;
                ev_cyc[n_evt]  = c;
                n_evt++;
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; chk_en = '0; chk_cond = '0; chk_mode = '0;
        clr = 1'b0; evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got=%0b exp=0", evt_valid);
        end
        n_vec++;
        if (fail_cnt !== '0 || hit_cnt !== '0) begin
            n_err++; $display("FAIL reset_cnt got=%h/%h exp=0/0", fail_cnt, hit_cnt);
        end
        n_vec++;
        if (any_fail !== 1'b0 || drop_cnt !== '0) begin
            n_err++; $display("FAIL reset_status got=%0b/%0d exp=0/0", any_fail, drop_cnt);
        end
        n_vec++;
        if (evt_chan !== 2'd0 || evt_kind !== 2'd0 || evt_ts !== 8'd0) begin
            n_err++; $display("FAIL reset_evt got=%0d/%0d/%0d exp=0/0/0", evt_chan, evt_kind, evt_ts);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_assert();
        chk_mode = 8'b0000_0001;
        repeat (5) @(negedge clk);
        chk_en = 4'b0001; chk_cond = 4'b0000;
        @(negedge clk);
        chk_en = '0;
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++; $display("FAIL single_early1 got=%0b exp=0", evt_valid);
        end
        @(negedge clk);
        n_vec++;
        if (fail_cnt[4:0] !== 5'd1 || any_fail !== 1'b1) begin
            n_err++; $display("FAIL single_cnt got=%0d/%0b exp=1/1", fail_cnt[4:0], any_fail);
        end
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++; $display("FAIL single_early2 got=%0b exp=0", evt_valid);
        end
        @(negedge clk);
        n_vec++;
        if (evt_valid !== 1'b1 || evt_chan !== 2'd0 || evt_kind !== 2'b01 || evt_ts !== 8'd5) begin
            n_err++;
            $display("FAIL single_evt got=v%0b c%0d k%0d t%0d exp=v1 c0 k1 t5",
                     evt_valid, evt_chan, evt_kind, evt_ts);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++; $display("FAIL single_pop got=%0b exp=0", evt_valid);
        end
    endtask

    task automatic test_cover_first_hit();
        chk_mode = 8'b0011_0000;
        chk_en = 4'b0100; chk_cond = 4'b0100;
        repeat (4) @(negedge clk);
        chk_en = '0; chk_cond = '0;
        collect(8);
        n_vec++;
        if (n_evt !== 1 || ev_chan[0] !== 2'd2 || ev_kind[0] !== 2'b11) begin
            n_err++;
            $display("FAIL cover_evt got=n%0d c%0d k%0d exp=n1 c2 k3", n_evt, ev_chan[0], ev_kind[0]);
        end
        n_vec++;
        if (hit_cnt[14:10] !== 5'd4) begin
            n_err++; $display("FAIL cover_hits got=%0d exp=4", hit_cnt[14:10]);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (hit_cnt[14:10] !== 5'd0 || any_fail !== 1'b0 || fail_cnt !== '0) begin
            n_err++;
            $display("FAIL cover_clr got=%0d/%0b/%h exp=0/0/0", hit_cnt[14:10], any_fail, fail_cnt);
        end
        chk_en = 4'b0100; chk_cond = 4'b0100;
        @(negedge clk);
        chk_en = '0; chk_cond = '0;
        collect(6);
        n_vec++;
        if (n_evt !== 1 || ev_chan[0] !== 2'd2 || ev_kind[0] !== 2'b11 || hit_cnt[14:10] !== 5'd1) begin
            n_err++;
            $display("FAIL cover_rearm got=n%0d c%0d k%0d h%0d exp=n1 c2 k3 h1",
                     n_evt, ev_chan[0], ev_kind[0], hit_cnt[14:10]);
        end
    endtask

    task automatic test_simultaneous();
        logic [TS_W-1:0] t0;
        chk_mode = 8'b0101_0101;
        t0 = tb_ts;
        chk_en = 4'b1111; chk_cond = 4'b0000;
        @(negedge clk);
        chk_en = '0;
        repeat (2) @(negedge clk);
        collect(8);
        n_vec++;
        if (n_evt !== 4 || drop_cnt !== '0) begin
            n_err++; $display("FAIL simul_count got=n%0d d%0d exp=n4 d0", n_evt, drop_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (ev_chan[k] !== 2'(k) || ev_kind[k] !== 2'b01 || ev_ts[k] !== t0 ||
                ev_cyc[k] !== ev_cyc[0] + k) begin
                n_err++;
                $display("FAIL simul_evt%0d got=c%0d k%0d t%0d y%0d exp=c%0d k1 t%0d y%0d",
                         k, ev_chan[k], ev_kind[k], ev_ts[k], ev_cyc[k], k, t0, ev_cyc[0] + k);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [TS_W-1:0] t0;
        chk_mode = 8'b0000_0100;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        t0 = tb_ts;
        chk_en = 4'b0010; chk_cond = 4'b0000;
        repeat (20) @(negedge clk);
        chk_en = '0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (fail_cnt[9:5] !== 5'd20 || drop_cnt !== 5'd11) begin
            n_err++; $display("FAIL bp_counts got=f%0d d%0d exp=f20 d11", fail_cnt[9:5], drop_cnt);
        end
        n_vec++;
        if (evt_valid !== 1'b1 || any_fail !== 1'b1) begin
            n_err++; $display("FAIL bp_status got=v%0b a%0b exp=v1 a1", evt_valid, any_fail);
        end
        collect(16);
        n_vec++;
        if (n_evt !== 9) begin
            n_err++; $display("FAIL bp_drain got=%0d exp=9", n_evt);
        end
        for (int k = 0; k < 9; k++) begin
            n_vec++;
            if (ev_chan[k] !== 2'd1 || ev_kind[k] !== 2'b01 || ev_ts[k] !== t0 + TS_W'(k)) begin
                n_err++;
                $display("FAIL bp_evt%0d got=c%0d k%0d t%0d exp=c1 k1 t%0d",
                         k, ev_chan[k], ev_kind[k], ev_ts[k], t0 + TS_W'(k));
            end
        end
    endtask

    task automatic test_saturation();
        chk_mode = 8'b0000_0001;
        evt_ready = 1'b1;
        chk_en = 4'b0001; chk_cond = 4'b0000;
        repeat (40) @(negedge clk);
        chk_en = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (fail_cnt[4:0] !== 5'd31) begin
            n_err++; $display("FAIL sat_cnt got=%0d exp=31", fail_cnt[4:0]);
        end
        clr = 1'b1; chk_en = 4'b0001;
        @(negedge clk);
        clr = 1'b0; chk_en = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (fail_cnt[4:0] !== 5'd1 || any_fail !== 1'b1 || drop_cnt !== '0) begin
            n_err++;
            $display("FAIL sat_clr got=f%0d a%0b d%0d exp=f1 a1 d0", fail_cnt[4:0], any_fail, drop_cnt);
        end
        repeat (4) @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        chk_mode = 8'b0000_0001;
        chk_en = 4'b0001; chk_cond = 4'b0000;
        repeat (3) @(negedge clk);
        chk_en = '0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (evt_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_prefill got=%0b exp=1", evt_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (evt_valid !== 1'b0 || fail_cnt !== '0 || any_fail !== 1'b0 || drop_cnt !== '0) begin
            n_err++;
            $display("FAIL mid_reset got=v%0b f%h a%0b d%0d exp=v0 f0 a0 d0",
                     evt_valid, fail_cnt, any_fail, drop_cnt);
        end
        rst = 1'b0;
        chk_en = 4'b0001;
        @(negedge clk);
        chk_en = '0;
        repeat (2) @(negedge clk);
        collect(5);
        n_vec++;
        if (n_evt !== 1 || ev_chan[0] !== 2'd0 || ev_ts[0] !== 8'd0) begin
            n_err++;
            $display("FAIL mid_ts got=n%0d c%0d t%0d exp=n1 c0 t0", n_evt, ev_chan[0], ev_ts[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_assert();
        test_cover_first_hit();
        test_simultaneous();
        test_backpressure();
        test_saturation();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sva_check_monitor.md
# sva_check_monitor

Parametrised, synthesizable multi-channel checker that turns per-cycle boolean check conditions into assert/assume/cover results with deferred ("final") evaluation: every condition is registered once and judged one cycle later, so combinational glitches never report. It keeps saturating per-channel counters, sticky status and a timestamped event stream drained through a valid/ready port. It sits beside datapath blocks in simulation and FPGA builds, where it is the hardware counterpart of immediate `assert final` / `assume final` / `cover #0` checks.

## Interface
- NUM_CH, 4: number of check channels (1..32)
- CNT_W, 16: width of each fail/hit counter
- TS_W, 32: timestamp width
- FIFO_DEPTH, 8: event FIFO entries (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- chk_en  in  NUM_CH  channel evaluates this cycle when 1
- chk_cond  in  NUM_CH  condition under check
- chk_mode  in  2*NUM_CH  per-channel mode: 00 off, 01 assert, 10 assume, 11 cover; quasi-static
- clr  in  1  clear counters and sticky state; pipelined with chk inputs
- evt_valid  out  1  event record available
- evt_ready  in  1  consumer accepts
- evt_chan  out  $clog2(NUM_CH) (min 1)  channel index of event
- evt_kind  out  2  01 assert-fail, 10 assume-fail, 11 cover-first-hit
- evt_ts  out  TS_W  timestamp of the evaluated cycle
- fail_cnt  out  NUM_CH*CNT_W  per-channel fail counts (assert/assume)
- hit_cnt  out  NUM_CH*CNT_W  per-channel cover hits
- any_fail  out  1  sticky: any assert/assume failure since reset/clr
- drop_cnt  out  CNT_W  events lost to pending-slot collision

## Operation
- Stage S0: chk_en, chk_cond, chk_mode, clr registered every cycle, along with ts (free-running, wraps 2^TS_W-1 -> 0).
- Stage S1 evaluation per channel, only if registered en=1:
  - assert/assume: cond=0 -> failure; fail_cnt++ (saturate at all-ones), any_fail<=1, event raised.
  - cover: cond=1 -> hit_cnt++ (saturate); event raised only on first hit since reset/clr (per-channel armed bit cleared on hit).
  - off: nothing.
- Each channel has one pending slot {kind, ts}. Raised event loads an empty slot; if slot already full, slot unchanged and drop_cnt++ (saturate). Counters count regardless.
- Arbiter: lowest-index full slot moves to FIFO each cycle FIFO not full; slot frees that cycle and may reload same cycle.
- FIFO full: slots hold; no loss until a slot collides.
- clr (registered): counters, drop_cnt, any_fail -> 0, cover armed bits -> 1; the same-cycle evaluation applies on top (clr + fail -> fail_cnt=1, any_fail=1). Pending slots and FIFO untouched.
- Output: evt_* driven from FIFO head; pop on evt_valid&&evt_ready. Simultaneous push and pop on full FIFO allowed.

## Timing
- Input sampled in cycle t -> counters/any_fail updated at end of t+1 -> slot loaded at end of t+1 -> FIFO at end of t+2 -> evt_valid high in cycle t+3 (empty FIFO, no contention).
- evt_* stable while evt_valid=1 and evt_ready=0.
- Reset: all outputs 0, ts=0, slots empty, FIFO empty, armed bits 1, S0 registers 0. Reset mid-operation discards in-flight S0 data, slots and FIFO contents.
- Throughput: one event per cycle into and out of FIFO.

## Structure
- Package sva_mon_pkg: mode_e (OFF/ASSERT/ASSUME/COVER), kind_e, evt_t struct {chan, kind, ts} parametrised via widths passed as localparams in the top.
- Sub-module sva_evt_fifo: synchronous FIFO of evt_t, DEPTH param, full/empty, push/pop same cycle.
- Arbiter and counters inline in top.

## Test plan
- Single assert fail: ch0 mode 01, en=1, cond=0 for one cycle at ts=5 -> fail_cnt[0]=1, any_fail=1, one event {chan 0, kind 01, ts 5}, evt_valid 3 cycles after input.
- Cover first-hit: ch2 mode 11, cond=1 for 4 cycles -> hit_cnt[2]=4, exactly one event kind 11; after clr, one more hit -> second event, hit_cnt=1.
- Simultaneous fails: ch0..3 all assert, fail together once -> four events in order chan 0,1,2,3 on consecutive cycles, identical ts, drop_cnt=0.
- Backpressure/drop: evt_ready=0, ch1 fails every cycle for 20 cycles, FIFO_DEPTH=8 -> 8 FIFO entries + 1 pending, drop_cnt=11, fail_cnt[1]=20; release ready -> 9 events drained.
- Saturation: CNT_W=4, 20 fails -> fail_cnt=15; clr coincident with fail -> fail_cnt=1.
- Reset mid-run: rst while FIFO holds 3 events -> evt_valid=0 next cycle, all counters 0, ts restarts at 0.
